// File: rtl/usr_pkg.sv
// Shared encodings for the universal burst shift register: opcodes, FSM states, burst directions.
package usr_pkg;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_SHL  = 2'b01;
   localparam logic [1:0] OP_SHR  = 2'b10;
   localparam logic [1:0] OP_LOAD = 2'b11;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_BURST = 2'b01,
      ST_DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit: 4:1 next-value mux (hold / left-shift / right-shift / load) feeding a clearable D flip-flop.
module usr_bit_cell
   import usr_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] sel,
   input  logic       shl_bit,
   input  logic       shr_bit,
   input  logic       load_bit,
   output logic       q
);

   logic q_nx;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      q_nx = q;
      case (sel)
         OP_SHL:  q_nx = shl_bit;
         OP_SHR:  q_nx = shr_bit;
         OP_LOAD: q_nx = load_bit;
         default: q_nx = q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; the async clear needs no clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q <= 1'b0;
      else          q <= q_nx;
   end

endmodule

// File: rtl/usr_burst_shift.sv
// Universal shift register with WIDTH-shift burst controller (busy/done handshake).
// Optional rotate mode is enabled by defining USR_ROTATE_EN.
module usr_burst_shift
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] d,
   input  logic             si_l,
   input  logic             si_r,
   input  logic             start,
   input  logic             dir,
   input  logic             rot,
   output logic [WIDTH-1:0] q,
   output logic             so_l,
   output logic             so_r,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state, state_nx;
   logic             dir_r, dir_nx;
   logic [CNT_W-1:0] count, count_nx;
   logic [1:0]       cell_op;
   logic             fill_l, fill_r;
   logic [WIDTH-1:0] shl_vec, shr_vec;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         dir_r <= DIR_LEFT;
         count <= '0;
      end else begin
         state <= state_nx;
         dir_r <= dir_nx;
         count <= count_nx;
      end
   end

   // The FSM owns the cells' opcode: single-step op only reaches them in IDLE without start.
   always_comb begin
      state_nx = state;
      dir_nx   = dir_r;
      count_nx = count;
      cell_op  = OP_HOLD;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nx = ST_BURST;
               dir_nx   = dir;
               count_nx = '0;
            end else begin
               cell_op = op;
            end
         end
         ST_BURST: begin
            cell_op = (dir_r == DIR_RIGHT) ? OP_SHR : OP_SHL;
            if (count <= LAST_CNT) count_nx = count + CNT_W'(1);
            if (count >= LAST_CNT) state_nx = ST_DONE;
         end
         ST_DONE:  state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   assign busy = (state == ST_BURST);
   assign done = (state == ST_DONE);

`ifdef USR_ROTATE_EN
   assign fill_l = rot ? q[WIDTH-1] : si_l;
   assign fill_r = rot ? q[0]       : si_r;
`else
   logic unused_rot;
   assign unused_rot = rot;
   assign fill_l     = si_l;
   assign fill_r     = si_r;
`endif

   assign shl_vec = {q[WIDTH-2:0], fill_l};
   assign shr_vec = {fill_r, q[WIDTH-1:1]};

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      usr_bit_cell u_cell (
         .clk      (clk),
         .reset_n  (reset_n),
         .sel      (cell_op),
         .shl_bit  (shl_vec[i]),
         .shr_bit  (shr_vec[i]),
         .load_bit (d[i]),
         .q        (q[i])
      );
   end

   assign so_l = q[WIDTH-1];
   assign so_r = q[0];

endmodule

// File: tb/tb_usr_burst_shift.sv
// Scoreboard bench for usr_burst_shift; expectations come from a behavioural shift model.
module tb_usr_burst_shift;
   import usr_pkg::*;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] q;
      logic         busy;
      logic         done;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [1:0]   op;
   logic [W-1:0] d;
   logic         si_l, si_r, start, dir, rot;
   logic [W-1:0] q;
   logic         so_l, so_r, busy, done;

   int           checks = 0;
   int           errors = 0;
   exp_t         sb[$];
   exp_t         e;
   logic [W-1:0] model;

   always #5 clk = ~clk;

   usr_burst_shift #(.WIDTH(W)) dut (
      .clk(clk), .reset_n(reset_n), .op(op), .d(d), .si_l(si_l), .si_r(si_r),
      .start(start), .dir(dir), .rot(rot), .q(q), .so_l(so_l), .so_r(so_r),
      .busy(busy), .done(done)
   );

   function automatic logic [W-1:0] shift_model(input logic [W-1:0] v, input logic left,
                                               input logic fl, input logic fr, input logic r);
`ifdef USR_ROTATE_EN
      if (r) begin
         fl = v[W-1];
         fr = v[0];
      end
`else
      if (r) begin
         fl = fl;
      end
`endif
      return left ? {v[W-2:0], fl} : {fr, v[W-1:1]};
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] o, input logic [W-1:0] dv, input logic sl,
                        input logic sr, input logic st, input logic dr);
      op = o; d = dv; si_l = sl; si_r = sr; start = st; dir = dr;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(OP_HOLD, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      rot = 1'b0;
      #1;
      checks++;
      if ({q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_initial: got q=%h busy=%b done=%b, want q=00 busy=0 done=0", q, busy, done);
      end
      #1 reset_n = 1'b1;
      drive(OP_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      model = 8'hFF;
      sb.push_back('{model, 1'b0, 1'b0});
      cycle();
      e = sb.pop_front();
      checks++;
      if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
         errors++;
         $display("FAIL reset_preload: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                  q, busy, done, e.q, e.busy, e.done);
      end
      op = OP_HOLD;
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      model = '0;
      sb.push_back('{model, 1'b0, 1'b0});
      #1;
      e = sb.pop_front();
      checks++;
      if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
         errors++;
         $display("FAIL reset_async: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                  q, busy, done, e.q, e.busy, e.done);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_single_step();
      logic [1:0]   ops[3] = '{OP_LOAD, OP_SHL, OP_SHR};
      logic [W-1:0] dat[3] = '{8'hA5, 8'h3C, 8'h3C};
      logic         sls[3] = '{1'b1, 1'b0, 1'b0};
      logic         srs[3] = '{1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         drive(ops[i], dat[i], sls[i], srs[i], 1'b0, 1'b0);
         case (ops[i])
            OP_LOAD: model = dat[i];
            OP_SHL:  model = shift_model(model, 1'b1, sls[i], srs[i], rot);
            OP_SHR:  model = shift_model(model, 1'b0, sls[i], srs[i], rot);
            default: model = model;
         endcase
         sb.push_back('{model, 1'b0, 1'b0});
         cycle();
         e = sb.pop_front();
         checks++;
         if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
            errors++;
            $display("FAIL single_step[%0d]: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     i, q, busy, done, e.q, e.busy, e.done);
         end
      end
      checks++;
      if ({so_l, so_r} !== {model[W-1], model[0]}) begin
         errors++;
         $display("FAIL serial_outs: got so_l=%b so_r=%b, want so_l=%b so_r=%b", so_l, so_r, model[W-1], model[0]);
      end
      op = OP_HOLD;
   endtask

   // Load, then one start cycle, then WIDTH shifts and the DONE cycle; counts busy-high samples.
   task automatic run_burst(input string name, input logic [W-1:0] init, input logic dr,
                            input logic sl, input logic sr);
      int busy_cycles = 0;
      drive(OP_LOAD, init, sl, sr, 1'b0, dr);
      model = init;
      sb.push_back('{model, 1'b0, 1'b0});
      cycle();
      e = sb.pop_front();
      checks++;
      if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
         errors++;
         $display("FAIL %s_load: got q=%h, want q=%h", name, q, e.q);
      end
      for (int k = 0; k <= W + 1; k++) begin
         drive((k == 0) ? OP_SHL : OP_HOLD, init, sl, sr, k == 0, dr);
         if (k >= 1 && k <= W) model = shift_model(model, dr == DIR_LEFT, sl, sr, rot);
         sb.push_back('{model, k < W, k == W});
         cycle();
         busy_cycles += int'(busy);
         e = sb.pop_front();
         checks++;
         if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
            errors++;
            $display("FAIL %s[%0d]: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     name, k, q, busy, done, e.q, e.busy, e.done);
         end
      end
      checks++;
      if (busy_cycles !== W) begin
         errors++;
         $display("FAIL %s_busy_len: got %0d cycles, want %0d", name, busy_cycles, W);
      end
   endtask

   task automatic test_burst_left();
      run_burst("burst_left", 8'h81, DIR_LEFT, 1'b1, 1'b0);
      checks++;
      if (q !== 8'hFF) begin
         errors++;
         $display("FAIL burst_left_final: got q=%h, want q=ff", q);
      end
   endtask

   task automatic test_burst_ignore();
      drive(OP_LOAD, 8'h80, 1'b0, 1'b0, 1'b0, DIR_RIGHT);
      model = 8'h80;
      cycle();
      drive(OP_HOLD, 8'h00, 1'b0, 1'b0, 1'b1, DIR_RIGHT);
      sb.push_back('{model, 1'b1, 1'b0});
      cycle();
      e = sb.pop_front();
      checks++;
      if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
         errors++;
         $display("FAIL ignore_start: got q=%h busy=%b, want q=%h busy=%b", q, busy, e.q, e.busy);
      end
      for (int k = 1; k <= W + 3; k++) begin
         drive((k <= W) ? OP_LOAD : OP_HOLD, 8'h00, 1'b1, 1'b0, (k == 3) || (k == W + 1), DIR_LEFT);
         if (k <= W) model = shift_model(model, 1'b0, 1'b1, 1'b0, rot);
         sb.push_back('{model, k < W, k == W});
         cycle();
         e = sb.pop_front();
         checks++;
         if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
            errors++;
            $display("FAIL ignore[%0d]: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     k, q, busy, done, e.q, e.busy, e.done);
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      drive(OP_LOAD, 8'hF0, 1'b0, 1'b0, 1'b0, DIR_LEFT);
      model = 8'hF0;
      cycle();
      drive(OP_HOLD, 8'hF0, 1'b0, 1'b0, 1'b1, DIR_LEFT);
      cycle();
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         model = shift_model(model, 1'b1, 1'b0, 1'b0, rot);
         sb.push_back('{model, 1'b1, 1'b0});
         cycle();
         e = sb.pop_front();
         checks++;
         if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
            errors++;
            $display("FAIL abort_shift[%0d]: got q=%h busy=%b, want q=%h busy=%b", k, q, busy, e.q, e.busy);
         end
      end
      @(negedge clk);
      #2 reset_n = 1'b0;
      model = '0;
      for (int k = 0; k < 3; k++) begin
         sb.push_back('{model, 1'b0, 1'b0});
         if (k == 0) #1;
         else cycle();
         e = sb.pop_front();
         checks++;
         if ({q, busy, done} !== {e.q, e.busy, e.done}) begin
            errors++;
            $display("FAIL abort_reset[%0d]: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                     k, q, busy, done, e.q, e.busy, e.done);
         end
      end
      @(negedge clk);
      reset_n = 1'b1;
      run_burst("post_abort", 8'h00, DIR_RIGHT, 1'b0, 1'b1);
   endtask

   task automatic test_rotate();
      rot = 1'b1;
`ifdef USR_ROTATE_EN
      drive(OP_LOAD, 8'h81, 1'b0, 1'b0, 1'b0, DIR_LEFT);
      model = 8'h81;
      cycle();
      for (int i = 0; i < 2; i++) begin
         drive((i == 0) ? OP_SHL : OP_SHR, 8'h00, 1'b0, 1'b0, 1'b0, DIR_LEFT);
         model = shift_model(model, i == 0, 1'b0, 1'b0, rot);
         sb.push_back('{model, 1'b0, 1'b0});
         cycle();
         e = sb.pop_front();
         checks++;
         if (q !== e.q) begin
            errors++;
            $display("FAIL rotate_step[%0d]: got q=%h, want q=%h", i, q, e.q);
         end
      end
      run_burst("rotate_burst", 8'h81, DIR_LEFT, 1'b0, 1'b0);
      checks++;
      if (q !== 8'h81) begin
         errors++;
         $display("FAIL rotate_burst_final: got q=%h, want q=81", q);
      end
`else
      drive(OP_LOAD, 8'h81, 1'b0, 1'b0, 1'b0, DIR_LEFT);
      cycle();
      drive(OP_SHL, 8'h00, 1'b0, 1'b0, 1'b0, DIR_LEFT);
      sb.push_back('{8'h02, 1'b0, 1'b0});
      cycle();
      e = sb.pop_front();
      checks++;
      if (q !== e.q) begin
         errors++;
         $display("FAIL rot_ignored: got q=%h, want q=%h", q, e.q);
      end
`endif
      rot = 1'b0;
      op  = OP_HOLD;
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_burst_left();
      test_burst_ignore();
      test_reset_mid_burst();
      test_rotate();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
